// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA stage sequencer: stage one-hot codes, FSM states, tile-count helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package rsa_pkg;

   // One-hot stage commands
   localparam logic [2:0] STAGE_IDLE = 3'b000;
   localparam logic [2:0] STAGE_PRD  = 3'b001;
   localparam logic [2:0] STAGE_NEW  = 3'b010;
   localparam logic [2:0] STAGE_UPD  = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_IN = 3'd1,
      ST_CALC    = 3'd2,
      ST_NL_OUT  = 3'd3,
      ST_DONE    = 3'd4
   } rsa_state_e;

   // Number of compute cycles for a stage. N = 3 + 2*landmark_num is the
   // state-vector length, wrapped to row_len+2 bits. The result is clamped
   // to [1, 2^cnt_dw] so that tiles-1 always fits the sequence counter.
   function automatic int tile_count(input logic [2:0] stage,
                                     input int         lm_num,
                                     input int         row_len,
                                     input int         x,
                                     input int         y,
                                     input int         cnt_dw);
      int n;
      int t;
      n = (3 + 2 * lm_num) & ((1 << (row_len + 2)) - 1);
      case (stage)
         STAGE_PRD: t = (n + x - 1) / x;
         STAGE_NEW: t = 2;
         STAGE_UPD: t = (n + y - 1) / y;
         default:   t = 1;
      endcase
      if (t > (1 << cnt_dw)) t = 1 << cnt_dw;
      if (t < 1)             t = 1;
      return t;
   endfunction

endpackage

// File: rtl/rsa_stage_ctrl_if.sv
// Handshake bundle between the stage sequencer, its command source and the nonlinear unit.
// Latency: n/a (wires only).
// Backpressure: one-hot valid/ready pairs per stage; master drives commands and nonlinear responses.
//   stage_val       master->slave  one-hot stage command
//   stage_rdy       slave->master  sequencer idle
//   nonlinear_s_val master->slave  nonlinear unit has operands (one-hot)
//   nonlinear_s_rdy master->slave  nonlinear unit accepts results (one-hot)
//   nonlinear_m_rdy slave->master  sequencer waiting for operands
//   nonlinear_m_val slave->master  sequencer results available
interface rsa_stage_ctrl_if;
   logic [2:0] stage_val;
   logic [2:0] stage_rdy;
   logic [2:0] nonlinear_s_val;
   logic [2:0] nonlinear_s_rdy;
   logic [2:0] nonlinear_m_rdy;
   logic [2:0] nonlinear_m_val;

   modport master (
      output stage_val, nonlinear_s_val, nonlinear_s_rdy,
      input  stage_rdy, nonlinear_m_rdy, nonlinear_m_val
   );

   modport slave (
      input  stage_val, nonlinear_s_val, nonlinear_s_rdy,
      output stage_rdy, nonlinear_m_rdy, nonlinear_m_val
   );
endinterface

// File: rtl/rsa_seq_cnt.sv
// Loadable down-counter with zero flag; stops at zero.
// Latency: load/decrement visible one cycle after the enabling edge.
// Backpressure: none; load has priority over decrement.
//   clk, sys_rst  clock, async active-low reset (count resets to 0)
//   load_i/load_val_i  synchronous load;  dec_i  decrement when non-zero
//   cnt_o/zero_o  current count and count==0
module rsa_seq_cnt #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         sys_rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rsa_stage_ctrl.sv
// Stage sequencer for the EKF-SLAM systolic array: command -> operand handshake -> tile compute -> result handshake.
// Latency: accept at edge k gives nonlinear_m_rdy at k+1; compute lasts `tiles` cycles; stage_rdy back 2 cycles after result handshake.
// Backpressure: waits indefinitely for nonlinear s_val/s_rdy unless RSA_WATCHDOG_EN is defined (31-cycle stall abort).
//   clk, sys_rst             clock, async active-low reset
//   landmark_num, l_k        landmark count / target index for NEW and UPD
//   bus (slave)              stage_val/stage_rdy, nonlinear_s_val/s_rdy, nonlinear_m_rdy/m_val
module rsa_stage_ctrl
   import rsa_pkg::*;
#(
   parameter int X          = 4,
   parameter int Y          = 4,
   parameter int L          = 4,
   parameter int RSA_DW     = 32,
   parameter int TB_AW      = 11,
   parameter int CB_AW      = 17,
   parameter int SEQ_CNT_DW = 5,
   parameter int ROW_LEN    = 10
) (
   input  logic               clk,
   input  logic               sys_rst,
   input  logic [ROW_LEN-1:0] landmark_num,
   input  logic [ROW_LEN-1:0] l_k,
   rsa_stage_ctrl_if.slave    bus
);

   rsa_state_e state_q;
   logic [2:0] cur_stage_q;
   logic [2:0] stage_rdy_q;
   logic [2:0] m_rdy_q;
   logic [2:0] m_val_q;

   logic                  accept;
   logic                  hs_in;
   logic                  hs_out;
   int                    tiles;
   logic [SEQ_CNT_DW-1:0] tiles_m1;
   logic [SEQ_CNT_DW-1:0] calc_cnt;
   logic                  calc_zero;
   logic                  wd_expired;

   // Only an exact one-hot command is accepted; NEW/UPD also need a landmark index in range.
   always_comb begin
      accept = 1'b0;
      case (bus.stage_val)
         STAGE_PRD:            accept = 1'b1;
         STAGE_NEW, STAGE_UPD: accept = (l_k <= landmark_num);
         default:              accept = 1'b0;
      endcase
   end

   assign hs_in  = (state_q == ST_WAIT_IN) && ((bus.nonlinear_s_val & cur_stage_q) != 3'b000);
   assign hs_out = (state_q == ST_NL_OUT)  && ((bus.nonlinear_s_rdy & cur_stage_q) != 3'b000);

   always_comb begin
      tiles    = tile_count(cur_stage_q, int'(landmark_num), ROW_LEN, X, Y, SEQ_CNT_DW);
      tiles_m1 = SEQ_CNT_DW'(tiles - 1);
   end

   rsa_seq_cnt #(.W(SEQ_CNT_DW)) u_calc_cnt (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .load_i     (hs_in),
      .load_val_i (tiles_m1),
      .dec_i      (state_q == ST_CALC),
      .cnt_o      (calc_cnt),
      .zero_o     (calc_zero)
   );

`ifdef RSA_WATCHDOG_EN
   logic                  wd_load;
   logic                  wd_run;
   logic                  wd_zero;
   logic [SEQ_CNT_DW-1:0] wd_cnt;
   // Loaded with all-ones minus one on entry to a waiting state, so the
   // abort fires on the (2^W - 1)-th stalled cycle in that state.
   localparam logic [SEQ_CNT_DW-1:0] WD_START = {{(SEQ_CNT_DW-1){1'b1}}, 1'b0};

   assign wd_load    = ((state_q == ST_IDLE) && accept) || ((state_q == ST_CALC) && calc_zero);
   assign wd_run     = (state_q == ST_WAIT_IN) || (state_q == ST_NL_OUT);
   assign wd_expired = wd_run && wd_zero && !hs_in && !hs_out;

   rsa_seq_cnt #(.W(SEQ_CNT_DW)) u_wd_cnt (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .load_i     (wd_load),
      .load_val_i (WD_START),
      .dec_i      (wd_run),
      .cnt_o      (wd_cnt),
      .zero_o     (wd_zero)
   );
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q     <= ST_IDLE;
         cur_stage_q <= STAGE_IDLE;
         stage_rdy_q <= 3'b111;
         m_rdy_q     <= 3'b000;
         m_val_q     <= 3'b000;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q     <= ST_WAIT_IN;
                  cur_stage_q <= bus.stage_val;
                  stage_rdy_q <= 3'b000;
                  m_rdy_q     <= bus.stage_val;
               end
            end
            ST_WAIT_IN: begin
               if (hs_in) begin
                  state_q <= ST_CALC;
                  m_rdy_q <= 3'b000;
               end else if (wd_expired) begin
                  state_q     <= ST_IDLE;
                  cur_stage_q <= STAGE_IDLE;
                  stage_rdy_q <= 3'b111;
                  m_rdy_q     <= 3'b000;
               end
            end
            ST_CALC: begin
               if (calc_zero) begin
                  state_q <= ST_NL_OUT;
                  m_val_q <= cur_stage_q;
               end
            end
            ST_NL_OUT: begin
               if (hs_out) begin
                  state_q <= ST_DONE;
                  m_val_q <= 3'b000;
               end else if (wd_expired) begin
                  state_q     <= ST_IDLE;
                  cur_stage_q <= STAGE_IDLE;
                  stage_rdy_q <= 3'b111;
                  m_val_q     <= 3'b000;
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               cur_stage_q <= STAGE_IDLE;
               stage_rdy_q <= 3'b111;
            end
            default: begin
               state_q     <= ST_IDLE;
               cur_stage_q <= STAGE_IDLE;
               stage_rdy_q <= 3'b111;
               m_rdy_q     <= 3'b000;
               m_val_q     <= 3'b000;
            end
         endcase
      end
   end

   assign bus.stage_rdy       = stage_rdy_q;
   assign bus.nonlinear_m_rdy = m_rdy_q;
   assign bus.nonlinear_m_val = m_val_q;

endmodule

// File: tb/tb_rsa_stage_ctrl.sv
// Self-checking bench for rsa_stage_ctrl: directed flows plus randomized transactions against a reference model.
// Latency: n/a (testbench).
// Backpressure: bench plays both command source and nonlinear unit with random delays.
module tb_rsa_stage_ctrl;

   localparam int X = 4;
   localparam int Y = 4;

   logic       clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [9:0] landmark_num = '0;
   logic [9:0] l_k = '0;

   int n_checks = 0;
   int n_errors = 0;

   rsa_stage_ctrl_if bus ();

   always #5 clk = ~clk;

   rsa_stage_ctrl dut (
      .clk          (clk),
      .sys_rst      (sys_rst),
      .landmark_num (landmark_num),
      .l_k          (l_k),
      .bus          (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: a stage occupies as many tiles as needed to cover the
   // 3+2*landmarks state vector, capped at 32 and never below one.
   function automatic int ref_tiles(input int stg, input int lm);
      int n;
      int d;
      int t;
      n = 3 + 2 * lm;
      if (stg == 2) return 2;
      d = (stg == 1) ? X : Y;
      t = 0;
      while (t * d < n) t++;
      if (t > 32) t = 32;
      if (t < 1)  t = 1;
      return t;
   endfunction

   function automatic bit ref_accept(input int stg, input int lm, input int lk);
      if (stg == 1) return 1'b1;
      if (stg == 2 || stg == 4) return (lk <= lm);
      return 1'b0;
   endfunction

   // One complete stage transaction. hold: cycles stage_val is driven;
   // noise: drive unrelated bits/commands that the sequencer must ignore.
   task automatic run_txn(input logic [2:0] stg, input int lm, input int lk,
                          input int dly_in, input int dly_out, input int hold, input bit noise);
      int cnt;
      logic [2:0] r;
      @(negedge clk);
      landmark_num  = 10'(lm);
      l_k           = 10'(lk);
      bus.stage_val = stg;
      @(negedge clk);
      bus.stage_val = (hold > 1) ? stg : 3'b000;
      if (!ref_accept(int'(stg), lm, lk)) begin
         chk("rej_stage_rdy", 32'(bus.stage_rdy), 32'd7);
         chk("rej_m_rdy", 32'(bus.nonlinear_m_rdy), 32'd0);
         bus.stage_val = 3'b000;
         return;
      end
      chk("acc_stage_rdy", 32'(bus.stage_rdy), 32'd0);
      chk("acc_m_rdy", 32'(bus.nonlinear_m_rdy), 32'(stg));
      for (int i = 0; i < dly_in; i++) begin
         if (noise) begin
            r = 3'($urandom);
            bus.stage_val       = 3'($urandom);
            bus.nonlinear_s_val = r & ~stg;
            bus.nonlinear_s_rdy = 3'($urandom);
         end
         @(negedge clk);
         bus.stage_val = 3'b000;
         chk("wait_m_rdy", 32'(bus.nonlinear_m_rdy), 32'(stg));
      end
      bus.nonlinear_s_val = noise ? (stg | 3'($urandom)) : stg;
      bus.nonlinear_s_rdy = 3'b000;
      @(negedge clk);
      bus.nonlinear_s_val = 3'b000;
      cnt = 0;
      while (bus.nonlinear_m_val == 3'b000 && cnt < 100) begin
         cnt++;
         chk("calc_m_rdy", 32'(bus.nonlinear_m_rdy), 32'd0);
         if (noise) begin
            bus.stage_val       = 3'($urandom);
            bus.nonlinear_s_val = 3'($urandom);
            bus.nonlinear_s_rdy = 3'($urandom);
         end
         @(negedge clk);
      end
      bus.stage_val       = 3'b000;
      bus.nonlinear_s_val = 3'b000;
      bus.nonlinear_s_rdy = 3'b000;
      chk("calc_len", 32'(cnt), 32'(ref_tiles(int'(stg), lm)));
      chk("m_val", 32'(bus.nonlinear_m_val), 32'(stg));
      for (int i = 0; i < dly_out; i++) begin
         if (noise) begin
            r = 3'($urandom);
            bus.nonlinear_s_rdy = r & ~stg;
            bus.nonlinear_s_val = 3'($urandom);
         end
         @(negedge clk);
         chk("hold_m_val", 32'(bus.nonlinear_m_val), 32'(stg));
      end
      bus.nonlinear_s_val = 3'b000;
      bus.nonlinear_s_rdy = noise ? (stg | 3'($urandom)) : stg;
      @(negedge clk);
      bus.nonlinear_s_rdy = 3'b000;
      chk("done_m_val", 32'(bus.nonlinear_m_val), 32'd0);
      chk("done_stage_rdy", 32'(bus.stage_rdy), 32'd0);
      @(negedge clk);
      chk("idle_stage_rdy", 32'(bus.stage_rdy), 32'd7);
   endtask

   initial begin
      logic [2:0] stg_tab [8];
      int cnt;
      stg_tab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b011, 3'b000};

      bus.stage_val       = 3'b000;
      bus.nonlinear_s_val = 3'b000;
      bus.nonlinear_s_rdy = 3'b000;

      // Asynchronous reset, observed before any clock edge.
      #1 sys_rst = 1'b0;
      #1;
      chk("rst_stage_rdy", 32'(bus.stage_rdy), 32'd7);
      chk("rst_m_rdy", 32'(bus.nonlinear_m_rdy), 32'd0);
      chk("rst_m_val", 32'(bus.nonlinear_m_val), 32'd0);
      @(negedge clk);
      sys_rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_stage_rdy", 32'(bus.stage_rdy), 32'd7);
      chk("idle_m_rdy", 32'(bus.nonlinear_m_rdy), 32'd0);
      chk("idle_m_val", 32'(bus.nonlinear_m_val), 32'd0);

      // Directed flows.
      run_txn(3'b001, 6, 0, 1, 1, 2, 1'b0);    // PRD, stage_val held 2 cycles, 4 tiles
      run_txn(3'b010, 6, 4, 1, 1, 1, 1'b0);    // NEW, 2 tiles
      run_txn(3'b010, 6, 7, 0, 0, 1, 1'b0);    // NEW out of range: rejected
      run_txn(3'b100, 6, 4, 5, 0, 1, 1'b0);    // UPD, s_rdy ready at m_val rise
      run_txn(3'b011, 6, 0, 0, 0, 1, 1'b0);    // multi-hot: ignored
      run_txn(3'b000, 6, 0, 0, 0, 1, 1'b0);    // zero: ignored
      run_txn(3'b100, 6, 4, 3, 2, 1, 1'b1);    // UPD with foreign s_val / busy commands
      run_txn(3'b001, 1023, 0, 0, 0, 1, 1'b0); // saturated tile count
      run_txn(3'b100, 0, 0, 0, 0, 1, 1'b0);    // minimum landmarks, l_k == landmark_num

      // Reset in the middle of CALC.
      @(negedge clk);
      landmark_num  = 10'd6;
      bus.stage_val = 3'b001;
      @(negedge clk);
      bus.stage_val       = 3'b000;
      bus.nonlinear_s_val = 3'b001;
      @(negedge clk);
      bus.nonlinear_s_val = 3'b000;
      @(negedge clk);
      sys_rst = 1'b0;
      #1;
      chk("midrst_stage_rdy", 32'(bus.stage_rdy), 32'd7);
      chk("midrst_m_rdy", 32'(bus.nonlinear_m_rdy), 32'd0);
      chk("midrst_m_val", 32'(bus.nonlinear_m_val), 32'd0);
      @(negedge clk);
      sys_rst = 1'b1;
      repeat (6) @(negedge clk);
      chk("postrst_m_val", 32'(bus.nonlinear_m_val), 32'd0);
      chk("postrst_stage_rdy", 32'(bus.stage_rdy), 32'd7);

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         run_txn(stg_tab[$urandom_range(7)], int'($urandom_range(80)), int'($urandom_range(90)),
                 int'($urandom_range(3)), int'($urandom_range(3)), 1, 1'($urandom));
      end

`ifdef RSA_WATCHDOG_EN
      // Operands withheld: abort after 31 cycles waiting.
      @(negedge clk);
      landmark_num  = 10'd6;
      bus.stage_val = 3'b001;
      @(negedge clk);
      bus.stage_val = 3'b000;
      cnt = 0;
      while (bus.nonlinear_m_rdy == 3'b001 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("wd_len", 32'(cnt), 32'd31);
      chk("wd_stage_rdy", 32'(bus.stage_rdy), 32'd7);
`else
      cnt = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
